// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: load/value request and scanned display outputs of the 7-segment driver
interface seg7_scan_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] value;
  logic                  load;
  logic                  blank_zeros;
  logic                  busy;
  logic [6:0]            out_cathode;
  logic [NUM_DIGITS-1:0] out_anode;
  modport master (output value, load, blank_zeros, input busy, out_cathode, out_anode);
  modport slave  (input value, load, blank_zeros, output busy, out_cathode, out_anode);
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: serial binary-to-BCD conversion feeding a multiplexed active-low 7-segment display
module seg7_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int REFRESH_DIV = 100000
) (
  input logic                clock,
  input logic                reset,
  seg7_scan_display_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [63:0] LIMIT = 64'(10 ** NUM_DIGITS - 1);
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  endfunction
  logic                  busy_q, busy_d, ovf_p_q, ovf_p_d, blank_p_q, blank_p_d, ovf_q, ovf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]         bcd_q, bcd_d, bcd_adj, digits_q, digits_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d, mask, anode_q, anode_d;
  logic [RW-1:0]         ref_q, ref_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [6:0]            cathode_q, cathode_d;
  logic                  accept, commit, zero_above, ref_wrap;
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    // a digit blanks only when it and every digit above it are zero
    zero_above = 1'b1;
    mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (bcd_q[4*i +: 4] == 4'd0);
      mask[i] = blank_p_q && zero_above;
    end
    accept = bus.load && !busy_q;
    commit = busy_q && (cnt_q == CW'(DATA_WIDTH));
    busy_d = accept ? 1'b1 : commit ? 1'b0 : busy_q;
    cnt_d = accept ? '0 : cnt_q + CW'(busy_q && !commit);
    sh_d = accept ? bus.value : busy_q ? sh_q << 1 : sh_q;
    bcd_d = accept ? '0 : (busy_q && !commit) ? {bcd_adj[BW-2:0], sh_q[DATA_WIDTH-1]} : bcd_q;
    ovf_p_d = accept ? (64'(bus.value) > LIMIT) : ovf_p_q;
    blank_p_d = accept ? bus.blank_zeros : blank_p_q;
    digits_d = commit ? bcd_q : digits_q;
    ovf_d = commit ? ovf_p_q : ovf_q;
    blank_d = commit ? mask : blank_q;
    ref_wrap = ref_q == RW'(REFRESH_DIV - 1);
    ref_d = ref_wrap ? '0 : ref_q + RW'(1);
    idx_d = !ref_wrap ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    anode_d = ~(NUM_DIGITS'(1) << idx_q);
    cathode_d = ovf_q ? 7'b1111110 : blank_q[idx_q] ? 7'b1111111 : seg(digits_q[4*idx_q +: 4]);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      sh_q      <= '0;
      bcd_q     <= '0;
      ovf_p_q   <= 1'b0;
      blank_p_q <= 1'b0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      blank_q   <= '0;
      ref_q     <= '0;
      idx_q     <= '0;
      anode_q   <= ~NUM_DIGITS'(1);
      cathode_q <= 7'b0000001;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      bcd_q     <= bcd_d;
      ovf_p_q   <= ovf_p_d;
      blank_p_q <= blank_p_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      blank_q   <= blank_d;
      ref_q     <= ref_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end
  assign bus.busy        = busy_q;
  assign bus.out_anode   = anode_q;
  assign bus.out_cathode = cathode_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: vector table plus hand sequences for load-while-busy and reset-abort
module tb_seg7_scan_display;
  localparam int ND = 4, DW = 16, RD = 4;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110,
    S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000,
    S9 = 7'b0000100, DASH = 7'b1111110, BLK = 7'b1111111;
  typedef struct {
    logic [15:0] v;
    logic        b;
    logic [27:0] e;
  } vec_t;
  logic clock = 1'b0, reset = 1'b1;
  int errors = 0, checks = 0;
  logic [6:0] exp_q[$];
  logic [6:0] obs[ND];
  vec_t tbl[10];
  always #5 clock = ~clock;
  seg7_scan_display_if #(.NUM_DIGITS(ND), .DATA_WIDTH(DW)) bus ();
  seg7_scan_display #(.NUM_DIGITS(ND), .DATA_WIDTH(DW), .REFRESH_DIV(RD)) dut (
    .clock(clock), .reset(reset), .bus(bus));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic expect_digits(input logic [27:0] e);
    for (int i = 0; i < ND; i++) exp_q.push_back(e[7*i +: 7]);
  endtask
  task automatic do_load(input logic [15:0] v, input logic b);
    @(posedge clock) #1;
    bus.value = v;
    bus.blank_zeros = b;
    bus.load = 1'b1;
    @(posedge clock) #1;
    bus.load = 1'b0;
  endtask
  task automatic wait_busy(output int n);
    n = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (bus.busy) n++;
      else if (n > 0) break;
    end
  endtask
  task automatic collect(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < ND; i++) obs[i] = 7'bx;
    for (int c = 0; c < RD * ND; c++) begin
      int found;
      @(negedge clock);
      found = 0;
      for (int k = 0; k < ND; k++)
        if (bus.out_anode == ~(4'(1) << k)) begin
          obs[k] = bus.out_cathode;
          found++;
        end
      if (found != 1) bad++;
    end
    check({name, " anode_onehot"}, bad, 0);
    for (int i = 0; i < ND; i++) check($sformatf("%s digit%0d", name, i), obs[i], exp_q.pop_front());
  endtask
  initial begin
    int n;
    bit injected;
    tbl[0] = '{16'd1234,  1'b0, {S1, S2, S3, S4}};
    tbl[1] = '{16'd7,     1'b1, {BLK, BLK, BLK, S7}};
    tbl[2] = '{16'd7,     1'b0, {S0, S0, S0, S7}};
    tbl[3] = '{16'd10000, 1'b0, {DASH, DASH, DASH, DASH}};
    tbl[4] = '{16'd9999,  1'b0, {S9, S9, S9, S9}};
    tbl[5] = '{16'd0,     1'b1, {BLK, BLK, BLK, S0}};
    tbl[6] = '{16'd1005,  1'b1, {S1, S0, S0, S5}};
    tbl[7] = '{16'd60,    1'b1, {BLK, BLK, S6, S0}};
    tbl[8] = '{16'd8,     1'b0, {S0, S0, S0, S8}};
    tbl[9] = '{16'd65535, 1'b1, {DASH, DASH, DASH, DASH}};
    bus.value = '0;
    bus.load = 1'b0;
    bus.blank_zeros = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clock);
      if (k == 0) begin
        check("reset cathode", bus.out_cathode, S0);
        check("reset busy", bus.busy, 0);
      end
      check($sformatf("scan anode k%0d", k), bus.out_anode,
            ~(4'(1) << ((k == 0 ? 0 : (k - 1) / 4) % 4)) & 4'hf);
    end
    foreach (tbl[i]) begin
      expect_digits(tbl[i].e);
      do_load(tbl[i].v, tbl[i].b);
      wait_busy(n);
      check($sformatf("busy_len v%0d", tbl[i].v), n, DW + 1);
      @(negedge clock);
      collect($sformatf("vec%0d", i));
    end
    // load ignored while busy; old dashes must persist until commit
    expect_digits({S1, S2, S3, S4});
    do_load(16'd1234, 1'b0);
    n = 0;
    injected = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (bus.busy) n++;
      else if (n > 0) break;
      if (n == 5 && !injected) begin
        bus.value = 16'd5678;
        bus.load = 1'b1;
        injected = 1;
      end
      if (n == 6) bus.load = 1'b0;
      if (n == 10) check("hold during conv", bus.out_cathode, DASH);
    end
    check("busy_len ignored load", n, DW + 1);
    @(negedge clock);
    collect("ignore");
    // reset in the middle of a conversion
    expect_digits({S0, S0, S0, S0});
    do_load(16'd5678, 1'b0);
    n = 0;
    for (int t = 0; t < 200 && n < 9; t++) begin
      @(negedge clock);
      if (bus.busy) n++;
    end
    check("reached busy 9", n, 9);
    reset = 1'b1;
    @(posedge clock) #1 reset = 1'b0;
    @(negedge clock);
    check("abort busy", bus.busy, 0);
    check("abort anode", bus.out_anode, 4'b1110);
    check("abort cathode", bus.out_cathode, S0);
    repeat (30) @(negedge clock);
    check("abort still idle", bus.busy, 0);
    collect("abort");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, binary input width, legal range 4..27.
REQ-003 The block SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is driven, legal range 2..2^24.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port: clock  input  1  system clock; all state on rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: value  input  DATA_WIDTH  unsigned binary value to display, sampled on accepted load.
REQ-008 Port: load  input  1  one-cycle request to convert and display value.
REQ-009 Port: blank_zeros  input  1  sampled with value; 1 blanks leading zero digits.
REQ-010 Port: busy  output  1  high while a conversion is in progress.
REQ-011 Port: out_cathode  output  7  segments {a,b,c,d,e,f,g}, bit6=a, bit0=g, active-low.
REQ-012 Port: out_anode  output  NUM_DIGITS  digit enables, active-low, one-hot-zero; bit0 = rightmost (least significant) digit.

Function
REQ-013 An accepted load SHALL be load=1 while busy=0; load while busy=1 SHALL be ignored without effect.
REQ-014 On accepted load the block SHALL capture value and blank_zeros and assert busy on the next cycle.
REQ-015 Conversion SHALL be sequential shift-add-3 (double dabble): one shift per cycle, DATA_WIDTH shift cycles plus one commit cycle; busy SHALL be high exactly DATA_WIDTH+1 cycles.
REQ-016 On the commit cycle all NUM_DIGITS BCD digits and the blank mask SHALL update atomically; the display SHALL show the previous value, unchanged, throughout conversion.
REQ-017 If captured value > 10^NUM_DIGITS - 1, the commit SHALL instead set overflow mode: every digit shows dash (1111110).
REQ-018 With blank_zeros=1, every digit above the most significant nonzero digit SHALL show blank (1111111); digit 0 SHALL never be blanked; blank_zeros=0 shows all zeros.
REQ-019 Segment table SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-020 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-021 out_anode and out_cathode SHALL be registered and change together on the cycle after the digit index changes or after commit; exactly one anode bit SHALL be 0 at all times.
REQ-022 The scan SHALL run continuously and independently of load/busy; a commit SHALL NOT reset the refresh counter or digit index.

Reset
REQ-023 On reset: busy=0, conversion state cleared, stored digits=0, overflow=0, blank mask clear, refresh counter=0, digit index=0.
REQ-024 After reset: out_anode = all ones except bit0=0; out_cathode=0000001 (digit "0").
REQ-025 Reset during conversion SHALL abort it; no partial result SHALL ever be displayed.

Verification (NUM_DIGITS=4, DATA_WIDTH=16, REFRESH_DIV=4)
REQ-026 Reset -> out_anode=1110, out_cathode=0000001, busy=0; anode advances 1110->1101->1011->0111->1110 every 4 cycles.
REQ-027 load value=1234, blank_zeros=0 -> busy high 17 cycles; then digits 0..3 show 1001100, 0000110, 0010010, 1001111.
REQ-028 load value=7, blank_zeros=1 -> digit0 0001111, digits 1..3 1111111; same with blank_zeros=0 -> digits 1..3 0000001.
REQ-029 load value=10000 -> all four digits 1111110; then load 9999 -> all digits 0000100.
REQ-030 load 1234, then load 5678 at busy cycle 5 -> second load ignored, display 1234; reset at busy cycle 9 of a new load -> display 0000, busy=0.
